// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared defaults for the CPU front end and the fetch FSM state encoding.
//   ADDR_WIDTH / DATA_WIDTH : PC and instruction widths
//   MEM_DEPTH               : number of valid instruction words (PCs 0..MEM_DEPTH-1)
//   RESET_PC                : PC loaded on reset
package cpu_pkg;

  localparam int          ADDR_WIDTH = 32;
  localparam int          DATA_WIDTH = 32;
  localparam int          MEM_DEPTH  = 11;
  localparam logic [31:0] RESET_PC   = 32'd0;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_controller_if.sv
// fetch_controller_if
//   Bundles the instruction-memory port, the decode handshake and the
//   redirect request seen by fetch_controller.
//   master : fetch side (drives address and the decode output)
//   slave  : memory/decode/branch side
interface fetch_controller_if #(
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH
);

  // instruction memory (combinational read)
  logic [ADDR_WIDTH-1:0] imem_address;
  logic [DATA_WIDTH-1:0] imem_instruction;

  // decode handshake
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;

  // branch / jump redirect
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  modport master (
    output imem_address, out_valid, out_instr, out_pc,
    input  imem_instruction, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_address, out_valid, out_instr, out_pc,
    output imem_instruction, out_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer
//   Two-entry FIFO of packed {pc, instr}. Head is always entry 0, so dout_o
//   comes straight from a register.
//   clk, reset_n : clock, async active-low reset
//   push_i       : write din_i (ignored if no slot is free after this cycle's pop)
//   pop_i        : drop the head (ignored when empty)
//   flush_i      : empty the FIFO; overrides push/pop
//   din_i/dout_o : entry in / head entry out
//   count_o      : occupancy 0..2
module fetch_buffer #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] e0_q, e1_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_ap;   // occupancy after this cycle's pop
  logic         pop_ok, push_ok;

  assign pop_ok  = pop_i && (cnt_q != 2'd0);
  assign cnt_ap  = cnt_q - {1'b0, pop_ok};
  assign push_ok = push_i && (cnt_ap != 2'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else if (flush_i) begin
      cnt_q <= 2'd0;
    end else begin
      // shift second entry to head when the full buffer pops
      if (pop_ok && cnt_q == 2'd2) e0_q <= e1_q;
      // new entry lands in the first free slot after the pop
      if (push_ok) begin
        if (cnt_ap == 2'd0) e0_q <= din_i;
        else                e1_q <= din_i;
      end
      cnt_q <= cnt_ap + {1'b0, push_ok};
    end
  end

  assign dout_o  = e0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller
//   Owns the PC in front of a combinational instruction memory. Fetches one
//   word per cycle into a 2-entry buffer and hands them to decode over
//   valid/ready. Handles start, redirect with flush, and halts once the PC
//   runs past MEM_DEPTH-1. A redirect to an out-of-range target sets a
//   sticky fault and halts.
//   clk, reset_n  : clock, async active-low reset
//   start         : one-cycle pulse, IDLE -> FETCH
//   bus (master)  : imem address/data, decode out_* handshake, redirect_*
//   halted        : FSM is in HALT
//   fault         : sticky, redirect target was out of range
module fetch_controller #(
  parameter int                    ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int                    DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int                    MEM_DEPTH  = cpu_pkg::MEM_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(cpu_pkg::RESET_PC)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  fetch_controller_if.master  bus,
  output logic                halted,
  output logic                fault
);
  import cpu_pkg::*;

  localparam int                    EW    = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(MEM_DEPTH);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  fault_q, fault_d;
  logic                  redir, pop, push;
  logic [1:0]            count;
  logic [EW-1:0]         head;

  // redirect is only honoured once running; it flushes and kills any pop
  assign redir = bus.redirect_valid && (state_q != FS_IDLE);
  assign pop   = bus.out_valid && bus.out_ready && !redir;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    push    = 1'b0;
    case (state_q)
      FS_IDLE: begin
        if (start) state_d = FS_FETCH;
      end
      FS_FETCH: begin
        if (redir) begin
          pc_d = bus.redirect_pc;
          if (bus.redirect_pc >= DEPTH) begin
            fault_d = 1'b1;
            state_d = FS_HALT;
          end
        end else if (pc_q >= DEPTH) begin
          state_d = FS_HALT;
        end else if (count != 2'd2 || pop) begin
          // full buffer still accepts when the head leaves this cycle
          push = 1'b1;
          pc_d = pc_q + ADDR_WIDTH'(1);
        end
      end
      FS_HALT: begin
        if (redir) begin
          if (bus.redirect_pc >= DEPTH) begin
            fault_d = 1'b1;
          end else begin
            pc_d    = bus.redirect_pc;
            state_d = FS_FETCH;
          end
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  fetch_buffer #(.W(EW)) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redir),
    .din_i   ({pc_q, bus.imem_instruction}),
    .dout_o  (head),
    .count_o (count)
  );

  assign bus.imem_address = pc_q;
  assign bus.out_valid    = (count != 2'd0);
  assign bus.out_pc       = head[EW-1:DATA_WIDTH];
  assign bus.out_instr    = head[DATA_WIDTH-1:0];
  assign halted           = (state_q == FS_HALT);
  assign fault            = fault_q;

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer in front of the combinational `instr_memory` that owns the program counter. It drives the word address, captures each returned instruction with its PC into a 2-entry buffer, and presents them to decode over a valid/ready handshake. It also handles start, branch/jump redirect with buffer flush, and halting when the PC runs past the end of the memory. It sits between `instr_memory` and the decode stage of the CPU.

## Interface
- `ADDR_WIDTH`, 32, width of PC and memory address (word-indexed, +1 per instruction)
- `DATA_WIDTH`, 32, instruction width
- `MEM_DEPTH`, 11, number of valid words; legal PCs are 0..MEM_DEPTH-1
- `RESET_PC`, 0, PC loaded at reset
- `clk` in 1: single clock, all state on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle pulse; leaves IDLE
- `imem_address` out ADDR_WIDTH: word address to `instr_memory`; equals the PC register
- `imem_instruction` in DATA_WIDTH: combinational read data for `imem_address`, valid same cycle
- `out_valid` out 1: buffer head holds an instruction
- `out_ready` in 1: decode accepts the head this cycle
- `out_instr` out DATA_WIDTH: head instruction
- `out_pc` out ADDR_WIDTH: PC of head instruction
- `redirect_valid` in 1: branch/jump taken this cycle
- `redirect_pc` in ADDR_WIDTH: target PC
- `halted` out 1: state is HALT
- `fault` out 1: sticky; a redirect target was ≥ MEM_DEPTH

## Operation
- States: IDLE, FETCH, HALT. Reset → IDLE.
- IDLE: no fetch. `start` → FETCH. `redirect_valid` is ignored in IDLE.
- FETCH, per cycle, in priority order:
  - `redirect_valid`:
    - flush buffer (count←0, any pop discarded), PC←`redirect_pc`, no push.
    - If `redirect_pc` ≥ MEM_DEPTH: `fault`←1 and state→HALT.
  - Otherwise, if PC ≥ MEM_DEPTH: state→HALT, no push.
  - Otherwise push:
    - Push {PC, `imem_instruction`} when count<2, or when count==2 and a pop occurs this cycle. Then PC←PC+1.
    - With no push slot, PC holds.
- Pop: `out_valid && out_ready` removes the head. This is legal in every state except during a redirect cycle.
- HALT:
  - No pushes. The buffer continues to drain normally.
  - `redirect_valid` with an in-range target: flush, PC←target, state→FETCH.
  - `redirect_valid` with an out-of-range target: stay in HALT, set `fault`.
- `fault` clears only on reset.
- PC arithmetic is modulo 2^ADDR_WIDTH. It never wraps in practice because the HALT check precedes the increment.
- The buffer is FIFO-ordered. Head is the oldest entry. Simultaneous push and pop keeps count unchanged.

## Timing
- Reset values:
  - state IDLE, PC=RESET_PC (so `imem_address`=RESET_PC), count=0
  - `out_valid`=0, `out_instr`=0, `out_pc`=0
  - `halted`=0, `fault`=0
- `start` in cycle n → FETCH in n+1. Instruction at RESET_PC pushed at the end of n+1. `out_valid`=1 in n+2.
- Fetch-to-output latency is 1 cycle. Throughput is 1 instruction/cycle while `out_ready`=1.
- Stall: `out_ready`=0 fills the buffer to 2 after two fetch cycles, then PC holds. When `out_ready` returns, there is no bubble: pop and push occur in the same cycle.
- Redirect in cycle n: `out_valid`=0 in n+1. The target instruction is fetched in n+1 and visible in n+2. Redirect penalty is 2 cycles.
- Reset asserted mid-operation: every register returns to its reset value immediately (asynchronous). The buffer contents are lost.
- `out_instr`/`out_pc` hold their last value when `out_valid`=0. Verification must not check them then.

## Structure
- Shared package `cpu_pkg`:
  - `ADDR_WIDTH`, `DATA_WIDTH`, `MEM_DEPTH`, `RESET_PC` defaults
  - state encoding constants `FS_IDLE`=2'd0, `FS_FETCH`=2'd1, `FS_HALT`=2'd2
- One sub-module: `fetch_buffer`, a 2-entry FIFO of {pc, instr}.
  - Ports: push, pop, din, dout, count, flush.
  - Async active-low reset.
- The top holds the FSM, PC, and fault logic.
- The bench instantiates `fetch_controller` together with `instr_memory` preloaded with Mem[i] = 32'h1111*i.

## Test plan
- Straight-line:
  - Stimulus: reset, `start` at cycle 2, `out_ready`=1.
  - Response: PCs 0..3 emerge with instrs 0000, 1111, 2222, 3333 on consecutive cycles starting at cycle 4.
- Backpressure:
  - Stimulus: `out_ready`=0 for 5 cycles after the first valid.
  - Response: count saturates at 2 and `imem_address` holds at 2. After release, PCs 0, 1, 2, 3 are delivered back-to-back with none dropped or duplicated.
- Redirect:
  - Stimulus: `redirect_valid` with `redirect_pc`=7 while the buffer holds PCs 2 and 3.
  - Response: both entries are discarded, `out_valid`=0 for one cycle, then PC 7 with instr 7777 appears.
- End of memory:
  - Stimulus: run from 0 with `out_ready`=1.
  - Response: PC 10 (instr AAAA) is the last output, `halted`=1, `out_valid` then falls to 0.
  - Follow-up: redirect to 1 → `halted`=0 and instr 1111 is delivered.
- Bad target:
  - Stimulus: redirect to 12.
  - Response: `halted`=1, `fault`=1, and no output.
  - Follow-up: redirect to 0 → fetch resumes while `fault` stays 1.
- Async reset:
  - Stimulus: assert `reset_n`=0 mid-cycle with the buffer full.
  - Response: `out_valid`, `halted`, and `fault` are 0 and `imem_address`=0 before the next clock edge. After release, the block stays in IDLE until `start`.
